csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Sequencer that owns the single-read/single-write port of the CSR register file.
- Arbitrates three requesters: trap entry (ecall/exception), mret, and Zicsr instructions (csrrw/csrrs/csrrc).
- Breaks each request into one-CSR-per-cycle accesses and returns either a redirect PC or the old CSR value.
- Sits between decode/execute and the CSR file.

Parameters:
- MSTATUS_A, 32'h300, mstatus address
- MTVEC_A, 32'h305, mtvec address
- MEPC_A, 32'h341, mepc address
- MCAUSE_A, 32'h342, mcause address

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- trap_valid_i  in  1  trap request
- trap_ready_o  out  1  trap accepted this cycle
- trap_pc_i  in  32  faulting PC (written to mepc)
- trap_cause_i  in  32  cause (written to mcause)
- mret_valid_i  in  1  mret request
- mret_ready_o  out  1  mret accepted
- csr_valid_i  in  1  Zicsr request
- csr_ready_o  out  1  Zicsr accepted
- csr_op_i  in  2  01=RW, 10=RS, 11=RC
- csr_addr_i  in  32  target CSR
- csr_src_i  in  32  rs1 value
- done_o  out  1  one-cycle completion pulse
- redirect_o  out  1  with done_o, PC redirect required
- redirect_pc_o  out  32  redirect target
- old_val_o  out  32  CSR value read for Zicsr (rd writeback)
- csr_rena_o  out  1  CSR file read enable
- csr_raddr_o  out  32  CSR file read address
- csr_rdata_i  in  32  CSR file read data (combinational)
- csr_wena_o  out  1  CSR file write enable
- csr_waddr_o  out  32  CSR file write address
- csr_wdata_o  out  32  CSR file write data

Behaviour:
- Reset (reset==0, any time, async): state=IDLE. Registered outputs done_o, redirect_o, redirect_pc_o, old_val_o = 0. CSR port outputs = 0 (no write). In-flight request is dropped; requester must re-issue.
- IDLE accepts one request per cycle, fixed priority trap > mret > csr. Only the winner's ready is 1. All readies = 0 outside IDLE. ready is combinational from state and valids. Request fields are captured into internal regs on accept.
- Trap path:
  - T_EPC: write mepc = pc.
  - T_CAUSE: write mcause = cause.
  - T_STAT: read mstatus; write back with MPIE(bit7) = old MIE(bit3), MIE = 0, MPP(12:11) = 2'b11; other bits unchanged.
  - T_VEC: read mtvec; next cycle done_o = 1, redirect_o = 1, redirect_pc_o = mtvec & ~32'h3.
  - Accept to done: 5 cycles.
- Mret path:
  - M_STAT: read mstatus; write MIE = old MPIE, MPIE = 1, MPP = 0.
  - M_EPC: read mepc; next cycle done_o = 1, redirect_o = 1, redirect_pc_o = mepc.
  - Accept to done: 3 cycles.
- Csr path:
  - C_RW: read addr, and write in the same cycle (read-before-write via combinational rdata).
    - RW: wdata = src.
    - RS: wdata = old | src.
    - RC: wdata = old & ~src.
    - Write suppressed (wena = 0) for RS/RC when src == 0.
  - Next cycle done_o = 1, redirect_o = 0, old_val_o = old. Unknown address: old = 0 as returned by the CSR file.
  - Accept to done: 2 cycles.
  - Op 00: treated as RS with src = 0 (read only).
- DONE: one cycle pulsing done_o, then IDLE. A new request can be accepted in the cycle after done_o.
- At most one CSR write per cycle. rena/wena are 0 in IDLE and DONE.
- redirect_pc_o and old_val_o hold their value until the next done_o.

Decomposition:
- Shared package/defines holds:
  - CSR addresses (reuse the existing MSTATUS/MTVEC/MEPC/MCAUSE defines)
  - mstatus bit positions (MIE = 3, MPIE = 7, MPP = 12:11)
  - Zicsr op encodings
  - FSM state encodings
- One sub-module is natural: csr_mstatus_upd, a combinational trap/mret mstatus transform (input old value plus mode; output new value).

Test Plan:
- trap pc = 0x8000_0010, cause = 11, mtvec = 0x8000_0103, mstatus = 0x8 -> writes mepc = 0x80000010, mcause = 0xB, mstatus = 0x1880; done + redirect to 0x8000_0100, 5 cycles after accept.
- mret with mepc = 0x8000_0014, mstatus = 0x1880 -> mstatus written 0x88; done + redirect to 0x8000_0014, 3 cycles after accept.
- csrrs mtvec src = 0x0 with mtvec = 0x1234 -> old_val_o = 0x1234, no write pulse, redirect_o = 0.
- csrrc mstatus src = 0x8 with mstatus = 0x88 -> write 0x80, old_val_o = 0x88.
- trap, mret and csr valid in the same cycle -> trap_ready only; mret accepted the cycle after done; then csr.
- reset pulled low during T_STAT -> all outputs 0 immediately; no further CSR writes; IDLE after release.

Source files
------------

// File: rtl/csr_trap_seq_pkg.sv
// Shared definitions for the CSR trap/mret/Zicsr sequencer.
package csr_trap_seq_pkg;

    // CSR addresses touched by the sequencer
    localparam logic [31:0] MSTATUS_A = 32'h300;
    localparam logic [31:0] MTVEC_A   = 32'h305;
    localparam logic [31:0] MEPC_A    = 32'h341;
    localparam logic [31:0] MCAUSE_A  = 32'h342;

    // mstatus field positions
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPP_HI   = 12;

    // Zicsr operation encodings
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Sequencer states: one CSR access per non-idle state
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_T_EPC   = 4'd1,
        S_T_CAUSE = 4'd2,
        S_T_STAT  = 4'd3,
        S_T_VEC   = 4'd4,
        S_M_STAT  = 4'd5,
        S_M_EPC   = 4'd6,
        S_C_RW    = 4'd7,
        S_DONE    = 4'd8
    } state_e;

    // mstatus transform selector
    typedef enum logic {
        UPD_TRAP = 1'b0,
        UPD_MRET = 1'b1
    } upd_mode_e;

endpackage

// File: rtl/csr_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry and mret.
module csr_mstatus_upd
    import csr_trap_seq_pkg::*;
(
    input  logic [31:0] old_i,
    input  upd_mode_e   mode_i,
    output logic [31:0] new_o
);

    // Trap stacks MIE into MPIE and enters M-mode; mret unstacks and clears MPP
    always_comb begin
        new_o = old_i;
        if (mode_i == UPD_TRAP) begin
            new_o[MPIE_BIT]        = old_i[MIE_BIT];
            new_o[MIE_BIT]         = 1'b0;
            new_o[MPP_HI:MPP_LO]   = 2'b11;
        end else begin
            new_o[MIE_BIT]         = old_i[MPIE_BIT];
            new_o[MPIE_BIT]        = 1'b1;
            new_o[MPP_HI:MPP_LO]   = 2'b00;
        end
    end

endmodule

// File: rtl/csr_trap_seq.sv
// Owns the CSR file port; sequences trap entry, mret and Zicsr accesses.
module csr_trap_seq
    import csr_trap_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        trap_valid_i,
    output logic        trap_ready_o,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_valid_i,
    output logic        mret_ready_o,
    input  logic        csr_valid_i,
    output logic        csr_ready_o,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_addr_i,
    input  logic [31:0] csr_src_i,
    output logic        done_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] old_val_o,
    output logic        csr_rena_o,
    output logic [31:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic        csr_wena_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    csr_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] src_q;
    logic        done_q;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] old_val_q;

    upd_mode_e   upd_mode;
    logic [31:0] mstatus_new;
    logic [31:0] eff_src;
    logic [31:0] zicsr_wdata;
    logic        zicsr_wena;

    // Fixed-priority accept: trap > mret > csr, only while idle
    always_comb begin
        trap_ready_o = (state_q == S_IDLE) && trap_valid_i;
        mret_ready_o = (state_q == S_IDLE) && mret_valid_i && !trap_valid_i;
        csr_ready_o  = (state_q == S_IDLE) && csr_valid_i && !trap_valid_i && !mret_valid_i;
    end

    assign upd_mode = (state_q == S_M_STAT) ? UPD_MRET : UPD_TRAP;

    csr_mstatus_upd u_mstatus_upd (
        .old_i  (csr_rdata_i),
        .mode_i (upd_mode),
        .new_o  (mstatus_new)
    );

    // Zicsr write value; op 00 behaves as a read-only set
    always_comb begin
        eff_src = (op_q == OP_NONE) ? 32'h0 : src_q;
        case (op_q)
            OP_RW:   zicsr_wdata = src_q;
            OP_RC:   zicsr_wdata = csr_rdata_i & ~eff_src;
            default: zicsr_wdata = csr_rdata_i | eff_src;
        endcase
        zicsr_wena = (op_q == OP_RW) || (eff_src != 32'h0);
    end

    // CSR file port: driven from the current state so read data feeds same-cycle writes
    always_comb begin
        csr_rena_o  = 1'b0;
        csr_raddr_o = 32'h0;
        csr_wena_o  = 1'b0;
        csr_waddr_o = 32'h0;
        csr_wdata_o = 32'h0;
        case (state_q)
            S_T_EPC: begin
                csr_wena_o  = 1'b1;
                csr_waddr_o = MEPC_A;
                csr_wdata_o = pc_q;
            end
            S_T_CAUSE: begin
                csr_wena_o  = 1'b1;
                csr_waddr_o = MCAUSE_A;
                csr_wdata_o = cause_q;
            end
            S_T_STAT, S_M_STAT: begin
                csr_rena_o  = 1'b1;
                csr_raddr_o = MSTATUS_A;
                csr_wena_o  = 1'b1;
                csr_waddr_o = MSTATUS_A;
                csr_wdata_o = mstatus_new;
            end
            S_T_VEC: begin
                csr_rena_o  = 1'b1;
                csr_raddr_o = MTVEC_A;
            end
            S_M_EPC: begin
                csr_rena_o  = 1'b1;
                csr_raddr_o = MEPC_A;
            end
            S_C_RW: begin
                csr_rena_o  = 1'b1;
                csr_raddr_o = addr_q;
                csr_wena_o  = zicsr_wena;
                csr_waddr_o = addr_q;
                csr_wdata_o = zicsr_wdata;
            end
            default: ;
        endcase
    end

    // Sequencer state, request capture and registered completion outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= 32'h0;
            cause_q       <= 32'h0;
            op_q          <= OP_NONE;
            addr_q        <= 32'h0;
            src_q         <= 32'h0;
            done_q        <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
            old_val_q     <= 32'h0;
        end else begin
            done_q     <= 1'b0;
            redirect_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trap_valid_i) begin
                        pc_q    <= trap_pc_i;
                        cause_q <= trap_cause_i;
                        state_q <= S_T_EPC;
                    end else if (mret_valid_i) begin
                        state_q <= S_M_STAT;
                    end else if (csr_valid_i) begin
                        op_q    <= csr_op_e'(csr_op_i);
                        addr_q  <= csr_addr_i;
                        src_q   <= csr_src_i;
                        state_q <= S_C_RW;
                    end
                end
                S_T_EPC:   state_q <= S_T_CAUSE;
                S_T_CAUSE: state_q <= S_T_STAT;
                S_T_STAT:  state_q <= S_T_VEC;
                S_T_VEC: begin
                    done_q        <= 1'b1;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_rdata_i & ~32'h3;
                    state_q       <= S_DONE;
                end
                S_M_STAT:  state_q <= S_M_EPC;
                S_M_EPC: begin
                    done_q        <= 1'b1;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_rdata_i;
                    state_q       <= S_DONE;
                end
                S_C_RW: begin
                    done_q    <= 1'b1;
                    old_val_q <= csr_rdata_i;
                    state_q   <= S_DONE;
                end
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign done_o        = done_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign old_val_o     = old_val_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq with a small CSR file attached.
module tb_csr_trap_seq;

    logic        clock;
    logic        reset;
    logic        trap_valid_i, trap_ready_o;
    logic [31:0] trap_pc_i, trap_cause_i;
    logic        mret_valid_i, mret_ready_o;
    logic        csr_valid_i, csr_ready_o;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_addr_i, csr_src_i;
    logic        done_o, redirect_o;
    logic [31:0] redirect_pc_o, old_val_o;
    logic        csr_rena_o, csr_wena_o;
    logic [31:0] csr_raddr_o, csr_rdata_i, csr_waddr_o, csr_wdata_o;

    int n_checks = 0;
    int n_pass   = 0;

    // CSR file model
    logic [31:0] m_mstatus = 32'h0;
    logic [31:0] m_mtvec   = 32'h0;
    logic [31:0] m_mepc    = 32'h0;
    logic [31:0] m_mcause  = 32'h0;
    int          wr_count  = 0;
    logic        pl_en     = 1'b0;
    logic [31:0] pl_addr   = 32'h0;
    logic [31:0] pl_data   = 32'h0;

    csr_trap_seq dut (
        .clock         (clock),
        .reset         (reset),
        .trap_valid_i  (trap_valid_i),
        .trap_ready_o  (trap_ready_o),
        .trap_pc_i     (trap_pc_i),
        .trap_cause_i  (trap_cause_i),
        .mret_valid_i  (mret_valid_i),
        .mret_ready_o  (mret_ready_o),
        .csr_valid_i   (csr_valid_i),
        .csr_ready_o   (csr_ready_o),
        .csr_op_i      (csr_op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_src_i     (csr_src_i),
        .done_o        (done_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .old_val_o     (old_val_o),
        .csr_rena_o    (csr_rena_o),
        .csr_raddr_o   (csr_raddr_o),
        .csr_rdata_i   (csr_rdata_i),
        .csr_wena_o    (csr_wena_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational read port; unknown addresses read as zero
    always_comb begin
        case (csr_raddr_o)
            32'h300: csr_rdata_i = m_mstatus;
            32'h305: csr_rdata_i = m_mtvec;
            32'h341: csr_rdata_i = m_mepc;
            32'h342: csr_rdata_i = m_mcause;
            default: csr_rdata_i = 32'h0;
        endcase
    end

    // Write port plus bench preload path
    always @(posedge clock) begin
        if (pl_en) begin
            case (pl_addr)
                32'h300: m_mstatus <= pl_data;
                32'h305: m_mtvec   <= pl_data;
                32'h341: m_mepc    <= pl_data;
                32'h342: m_mcause  <= pl_data;
                default: ;
            endcase
        end else if (csr_wena_o) begin
            wr_count <= wr_count + 1;
            case (csr_waddr_o)
                32'h300: m_mstatus <= csr_wdata_o;
                32'h305: m_mtvec   <= csr_wdata_o;
                32'h341: m_mepc    <= csr_wdata_o;
                32'h342: m_mcause  <= csr_wdata_o;
                default: ;
            endcase
        end
    end

    task automatic set_csr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    // Called at the negedge after the accept edge; returns edges from accept to done
    task automatic wait_done(output int lat);
        lat = 1;
        while (done_o !== 1'b1 && lat < 50) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    // Issue a Zicsr request and return latency
    task automatic issue_csr(input logic [1:0] op, input logic [31:0] a, input logic [31:0] s,
                             output int lat, output logic rdy);
        @(negedge clock);
        csr_valid_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_src_i = s;
        #1 rdy = csr_ready_o;
        @(posedge clock);
        @(negedge clock);
        csr_valid_i = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        trap_valid_i = 0; mret_valid_i = 0; csr_valid_i = 0;
        trap_pc_i = 0; trap_cause_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_src_i = 0;
        repeat (2) @(negedge clock);
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
        n_checks++; if (redirect_pc_o !== 32'h0) $display("FAIL reset_rpc: got %h want 0", redirect_pc_o); else n_pass++;
        n_checks++; if (old_val_o !== 32'h0) $display("FAIL reset_old: got %h want 0", old_val_o); else n_pass++;
        n_checks++; if ({csr_rena_o, csr_wena_o} !== 2'b00) $display("FAIL reset_port: got %b want 00", {csr_rena_o, csr_wena_o}); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_trap;
        int lat; int w0;
        set_csr(32'h305, 32'h8000_0103);
        set_csr(32'h300, 32'h8);
        @(negedge clock);
        w0 = wr_count;
        trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0010; trap_cause_i = 32'd11;
        #1;
        n_checks++; if (trap_ready_o !== 1'b1) $display("FAIL trap_ready: got %b want 1", trap_ready_o); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        trap_valid_i = 1'b0;
        wait_done(lat);
        n_checks++; if (lat !== 5) $display("FAIL trap_latency: got %0d want 5", lat); else n_pass++;
        n_checks++; if (redirect_o !== 1'b1) $display("FAIL trap_redirect: got %b want 1", redirect_o); else n_pass++;
        n_checks++; if (redirect_pc_o !== 32'h8000_0100) $display("FAIL trap_rpc: got %h want 80000100", redirect_pc_o); else n_pass++;
        n_checks++; if (m_mepc !== 32'h8000_0010) $display("FAIL trap_mepc: got %h want 80000010", m_mepc); else n_pass++;
        n_checks++; if (m_mcause !== 32'hB) $display("FAIL trap_mcause: got %h want 0000000b", m_mcause); else n_pass++;
        n_checks++; if (m_mstatus !== 32'h1880) $display("FAIL trap_mstatus: got %h want 00001880", m_mstatus); else n_pass++;
        n_checks++; if (wr_count - w0 !== 3) $display("FAIL trap_writes: got %0d want 3", wr_count - w0); else n_pass++;
        @(negedge clock);
        n_checks++; if (done_o !== 1'b0) $display("FAIL trap_done_pulse: got %b want 0", done_o); else n_pass++;
    endtask

    task automatic test_mret;
        int lat; int w0;
        set_csr(32'h341, 32'h8000_0014);
        set_csr(32'h300, 32'h1880);
        @(negedge clock);
        w0 = wr_count;
        mret_valid_i = 1'b1;
        #1;
        n_checks++; if (mret_ready_o !== 1'b1) $display("FAIL mret_ready: got %b want 1", mret_ready_o); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        mret_valid_i = 1'b0;
        wait_done(lat);
        n_checks++; if (lat !== 3) $display("FAIL mret_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (redirect_o !== 1'b1) $display("FAIL mret_redirect: got %b want 1", redirect_o); else n_pass++;
        n_checks++; if (redirect_pc_o !== 32'h8000_0014) $display("FAIL mret_rpc: got %h want 80000014", redirect_pc_o); else n_pass++;
        n_checks++; if (m_mstatus !== 32'h88) $display("FAIL mret_mstatus: got %h want 00000088", m_mstatus); else n_pass++;
        n_checks++; if (wr_count - w0 !== 1) $display("FAIL mret_writes: got %0d want 1", wr_count - w0); else n_pass++;
    endtask

    task automatic test_zicsr;
        int lat; int w0; logic rdy;
        // csrrs with zero source: read only
        set_csr(32'h305, 32'h1234);
        w0 = wr_count;
        issue_csr(2'b10, 32'h305, 32'h0, lat, rdy);
        n_checks++; if (rdy !== 1'b1) $display("FAIL rs_ready: got %b want 1", rdy); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL rs_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (old_val_o !== 32'h1234) $display("FAIL rs_old: got %h want 00001234", old_val_o); else n_pass++;
        n_checks++; if (redirect_o !== 1'b0) $display("FAIL rs_redirect: got %b want 0", redirect_o); else n_pass++;
        n_checks++; if (wr_count - w0 !== 0) $display("FAIL rs_writes: got %0d want 0", wr_count - w0); else n_pass++;
        // csrrc clears MIE
        set_csr(32'h300, 32'h88);
        w0 = wr_count;
        issue_csr(2'b11, 32'h300, 32'h8, lat, rdy);
        n_checks++; if (old_val_o !== 32'h88) $display("FAIL rc_old: got %h want 00000088", old_val_o); else n_pass++;
        n_checks++; if (m_mstatus !== 32'h80) $display("FAIL rc_mstatus: got %h want 00000080", m_mstatus); else n_pass++;
        n_checks++; if (wr_count - w0 !== 1) $display("FAIL rc_writes: got %0d want 1", wr_count - w0); else n_pass++;
        // csrrw to an unimplemented CSR reads zero but still writes
        w0 = wr_count;
        issue_csr(2'b01, 32'h7C0, 32'hDEAD, lat, rdy);
        n_checks++; if (old_val_o !== 32'h0) $display("FAIL rw_unk_old: got %h want 0", old_val_o); else n_pass++;
        n_checks++; if (wr_count - w0 !== 1) $display("FAIL rw_unk_writes: got %0d want 1", wr_count - w0); else n_pass++;
        // op 00 is read-only regardless of source
        w0 = wr_count;
        issue_csr(2'b00, 32'h300, 32'hFFFF, lat, rdy);
        n_checks++; if (old_val_o !== 32'h80) $display("FAIL op0_old: got %h want 00000080", old_val_o); else n_pass++;
        n_checks++; if (wr_count - w0 !== 0) $display("FAIL op0_writes: got %0d want 0", wr_count - w0); else n_pass++;
        // csrrs with non-zero source sets bits
        set_csr(32'h305, 32'h1234);
        issue_csr(2'b10, 32'h305, 32'h1, lat, rdy);
        n_checks++; if (m_mtvec !== 32'h1235) $display("FAIL rs_set: got %h want 00001235", m_mtvec); else n_pass++;
    endtask

    task automatic test_priority;
        int lat;
        set_csr(32'h342, 32'h0);
        @(negedge clock);
        trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0200; trap_cause_i = 32'd2;
        mret_valid_i = 1'b1;
        csr_valid_i = 1'b1; csr_op_i = 2'b10; csr_addr_i = 32'h342; csr_src_i = 32'h0;
        #1;
        n_checks++; if ({trap_ready_o, mret_ready_o, csr_ready_o} !== 3'b100)
            $display("FAIL prio_readies: got %b want 100", {trap_ready_o, mret_ready_o, csr_ready_o}); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        trap_valid_i = 1'b0;
        n_checks++; if ({trap_ready_o, mret_ready_o, csr_ready_o} !== 3'b000)
            $display("FAIL prio_busy_readies: got %b want 000", {trap_ready_o, mret_ready_o, csr_ready_o}); else n_pass++;
        wait_done(lat);
        n_checks++; if (lat !== 5) $display("FAIL prio_trap_latency: got %0d want 5", lat); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if ({mret_ready_o, csr_ready_o} !== 2'b10)
            $display("FAIL prio_mret_ready: got %b want 10", {mret_ready_o, csr_ready_o}); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        mret_valid_i = 1'b0;
        wait_done(lat);
        n_checks++; if (lat !== 3) $display("FAIL prio_mret_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (redirect_pc_o !== 32'h8000_0200) $display("FAIL prio_mret_rpc: got %h want 80000200", redirect_pc_o); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (csr_ready_o !== 1'b1) $display("FAIL prio_csr_ready: got %b want 1", csr_ready_o); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        csr_valid_i = 1'b0;
        wait_done(lat);
        n_checks++; if (lat !== 2) $display("FAIL prio_csr_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (old_val_o !== 32'h2) $display("FAIL prio_csr_old: got %h want 00000002", old_val_o); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int w0;
        set_csr(32'h300, 32'h8);
        @(negedge clock);
        trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0300; trap_cause_i = 32'd7;
        @(posedge clock);
        @(negedge clock);
        trap_valid_i = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        n_checks++; if (csr_wena_o !== 1'b1 || csr_waddr_o !== 32'h300)
            $display("FAIL mid_in_tstat: got wena %b waddr %h want 1 00000300", csr_wena_o, csr_waddr_o); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if ({done_o, redirect_o, csr_rena_o, csr_wena_o} !== 4'b0000)
            $display("FAIL mid_ctrl: got %b want 0000", {done_o, redirect_o, csr_rena_o, csr_wena_o}); else n_pass++;
        n_checks++; if (redirect_pc_o !== 32'h0 || old_val_o !== 32'h0)
            $display("FAIL mid_data: got rpc %h old %h want 0 0", redirect_pc_o, old_val_o); else n_pass++;
        n_checks++; if ({csr_raddr_o, csr_waddr_o, csr_wdata_o} !== 96'h0)
            $display("FAIL mid_port: got %h want 0", {csr_raddr_o, csr_waddr_o, csr_wdata_o}); else n_pass++;
        w0 = wr_count;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (wr_count - w0 !== 0) $display("FAIL mid_writes: got %0d want 0", wr_count - w0); else n_pass++;
        n_checks++; if (m_mstatus !== 32'h8) $display("FAIL mid_mstatus: got %h want 00000008", m_mstatus); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL mid_no_done: got %b want 0", done_o); else n_pass++;
        trap_valid_i = 1'b1;
        #1;
        n_checks++; if (trap_ready_o !== 1'b1) $display("FAIL mid_idle: got %b want 1", trap_ready_o); else n_pass++;
        trap_valid_i = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_trap();
        test_mret();
        test_zicsr();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
